aip_crc32: RTL and testbench

AIP_CRC32 -- requirements
Module: aip_crc32

---
 rtl/aip_crc32_pkg.sv | 26 ++
 rtl/aip_crc32_if.sv | 28 ++
 rtl/aip_crc32_step.sv | 36 +++
 rtl/aip_crc32.sv | 186 ++++++++++++++++++
 tb/tb_aip_crc32.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/aip_crc32_pkg.sv
// ============================================================================
// Module      : aip_crc32_pkg
// Description : Shared constants and types for the aip_crc32 CRC engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aip_crc32_pkg;

    localparam logic [4:0]  c_code_mem_in = 5'h00;
    localparam logic [4:0]  c_code_config = 5'h01;
    localparam logic [4:0]  c_code_result = 5'h02;
    localparam logic [4:0]  c_code_status = 5'h03;
    localparam logic [4:0]  c_code_clear  = 5'h04;

    localparam logic [31:0] c_crc_init    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/aip_crc32_if.sv
// ============================================================================
// Module      : aip_crc32_if
// Description : IP-side access port of aip_crc32 (bus master / CRC slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aip_crc32_if;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [4:0]  conf_dbus;
    logic        read;
    logic        write;
    logic        start;
    logic        int_req;

    modport master (
        output data_in, conf_dbus, read, write, start,
        input  data_out, int_req
    );

    modport slave (
        input  data_in, conf_dbus, read, write, start,
        output data_out, int_req
    );
endinterface

`default_nettype wire

// File: rtl/aip_crc32_step.sv
// ============================================================================
// Module      : aip_crc32_step
// Description : Combinational reflected CRC-32 update over one 32-bit word,
//               consumed byte [7:0] first, each byte LSB-first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aip_crc32_step #(
    parameter logic [31:0] POLY = 32'hEDB8_8320
) (
    input  wire logic [31:0] i_crc_in,
    input  wire logic [31:0] i_word,
    output logic      [31:0] o_crc_out
);

    logic [31:0] w_crc;

    // Reflected CRC: folding the whole word in first and shifting 32 times is
    // identical to processing its four bytes low byte first.
    always_comb begin
        w_crc = i_crc_in ^ i_word;
        for (int i = 0; i < 32; i++) begin
            if (w_crc[0]) begin
                w_crc = (w_crc >> 1) ^ POLY;
            end else begin
                w_crc = w_crc >> 1;
            end
        end
    end

    assign o_crc_out = w_crc;

endmodule

`default_nettype wire

// File: rtl/aip_crc32.sv
// ============================================================================
// Module      : aip_crc32
// Description : Memory-buffered CRC-32 engine with register access port and
//               level interrupt on completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aip_crc32
    import aip_crc32_pkg::*;
#(
    parameter int          MEM_DEPTH = 16,
    parameter logic [31:0] POLY      = 32'hEDB8_8320
) (
    input  wire logic   clk,
    input  wire logic   rst,
    aip_crc32_if.slave  bus
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int LW = AW + 1;

    logic [31:0]   mem [MEM_DEPTH];
    logic          mem_we;

    state_t        state_q,    state_d;
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [LW-1:0] rd_idx_q,   rd_idx_d;
    logic [LW-1:0] length_q,   length_d;
    logic          int_en_q,   int_en_d;
    logic          done_q,     done_d;
    logic          int_req_q,  int_req_d;
    logic [31:0]   crc_q,      crc_d;
    logic [31:0]   result_q,   result_d;
    logic [31:0]   data_out_q, data_out_d;
    logic [31:0]   word_q,     word_d;
    logic          vld_q,      vld_d;

    logic          w_busy;
    logic          w_wr_ok;
    logic [31:0]   w_step_crc;
    logic          w_unused;

    assign w_busy   = (state_q != ST_IDLE);
    // The start cycle itself blocks buffer/config writes so the operation
    // sees only the pre-start length and memory contents.
    assign w_wr_ok  = bus.write && !w_busy && !bus.start;
    assign w_unused = &{1'b0, bus.data_in[30:9]};

    aip_crc32_step #(
        .POLY (POLY)
    ) u_step (
        .i_crc_in  (crc_q),
        .i_word    (word_q),
        .o_crc_out (w_step_crc)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_idx_d   = rd_idx_q;
        length_d   = length_q;
        int_en_d   = int_en_q;
        done_d     = done_q;
        int_req_d  = int_req_q;
        crc_d      = crc_q;
        result_d   = result_q;
        data_out_d = data_out_q;
        word_d     = word_q;
        vld_d      = vld_q;
        mem_we     = 1'b0;

        if (bus.write) begin
            case (bus.conf_dbus)
                c_code_mem_in: begin
                    if (w_wr_ok) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                    end
                end
                c_code_config: begin
                    if (w_wr_ok) begin
                        if (bus.data_in[8:0] > 9'(MEM_DEPTH)) begin
                            length_d = LW'(MEM_DEPTH);
                        end else begin
                            length_d = LW'(bus.data_in[8:0]);
                        end
                        int_en_d = bus.data_in[31];
                        wr_ptr_d = '0;
                    end
                end
                c_code_clear: begin
                    done_d    = 1'b0;
                    int_req_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (bus.read) begin
            case (bus.conf_dbus)
                c_code_result: data_out_d = result_q;
                c_code_status: data_out_d = {29'b0, int_req_q, w_busy, done_q};
                default: ;
            endcase
        end

        // FSM updates come last so a completing operation wins over CLEAR.
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    crc_d    = c_crc_init;
                    rd_idx_d = '0;
                    vld_d    = 1'b0;
                    done_d   = 1'b0;
                    state_d  = (length_q == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                // Fetch of word n overlaps the CRC update of word n-1.
                if (rd_idx_q != length_q) begin
                    word_d   = mem[rd_idx_q[AW-1:0]];
                    vld_d    = 1'b1;
                    rd_idx_d = rd_idx_q + LW'(1);
                end else begin
                    vld_d    = 1'b0;
                end
                if (vld_q) begin
                    crc_d = w_step_crc;
                    if (rd_idx_q == length_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                result_d  = ~crc_q;
                done_d    = 1'b1;
                int_req_d = int_en_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_idx_q   <= '0;
            length_q   <= '0;
            int_en_q   <= 1'b0;
            done_q     <= 1'b0;
            int_req_q  <= 1'b0;
            crc_q      <= c_crc_init;
            result_q   <= '0;
            data_out_q <= '0;
            word_q     <= '0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_idx_q   <= rd_idx_d;
            length_q   <= length_d;
            int_en_q   <= int_en_d;
            done_q     <= done_d;
            int_req_q  <= int_req_d;
            crc_q      <= crc_d;
            result_q   <= result_d;
            data_out_q <= data_out_d;
            word_q     <= word_d;
            vld_q      <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.int_req  = int_req_q;

endmodule

`default_nettype wire

// File: tb/tb_aip_crc32.sv
// ============================================================================
// Module      : tb_aip_crc32
// Description : Directed self-checking bench for aip_crc32.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aip_crc32;
    import aip_crc32_pkg::*;

    localparam int          MEM_DEPTH = 16;
    localparam logic [31:0] POLY      = 32'hEDB8_8320;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          lat;
    logic [31:0] rdata;
    logic [31:0] gold [MEM_DEPTH];
    logic [31:0] w;

    always #5 clk = ~clk;

    aip_crc32_if bus ();

    aip_crc32 #(
        .MEM_DEPTH (MEM_DEPTH),
        .POLY      (POLY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bytewise reference over gold[0..n-1].
    function automatic logic [31:0] crc_model(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int wi = 0; wi < n; wi++) begin
            for (int b = 0; b < 4; b++) begin
                c = c ^ {24'b0, gold[wi][8*b +: 8]};
                for (int k = 0; k < 8; k++) begin
                    c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
                end
            end
        end
        return ~c;
    endfunction

    task automatic wr(input logic [4:0] code, input logic [31:0] d);
        @(negedge clk);
        bus.write = 1'b1; bus.conf_dbus = code; bus.data_in = d;
        @(posedge clk); #1;
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] code, output logic [31:0] d);
        @(negedge clk);
        bus.read = 1'b1; bus.conf_dbus = code;
        @(posedge clk); #1;
        bus.read = 1'b0;
        d = bus.data_out;
    endtask

    task automatic rdwr(input logic [4:0] code, input logic [31:0] d, output logic [31:0] q);
        @(negedge clk);
        bus.read = 1'b1; bus.write = 1'b1; bus.conf_dbus = code; bus.data_in = d;
        @(posedge clk); #1;
        bus.read = 1'b0; bus.write = 1'b0;
        q = bus.data_out;
    endtask

    task automatic go();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic go_wr(input logic [4:0] code, input logic [31:0] d);
        @(negedge clk);
        bus.start = 1'b1; bus.write = 1'b1; bus.conf_dbus = code; bus.data_in = d;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.write = 1'b0;
    endtask

    // Edges counted from the start edge to the one raising int_req; 0 on timeout.
    task automatic wait_int(input int budget, output int n);
        n = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk); #1;
            if (bus.int_req) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_in = '0; bus.conf_dbus = '0;
        bus.read = 1'b0; bus.write = 1'b0; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        check_val("rst_int_req", {31'b0, bus.int_req}, 32'h0);
        check_val("rst_data_out", bus.data_out, 32'h0);
        rd(c_code_status, rdata); check_val("rst_status", rdata, 32'h0);
        rd(c_code_result, rdata); check_val("rst_result", rdata, 32'h0);

        // One zero word.
        wr(c_code_config, 32'h0000_0001);
        wr(c_code_mem_in, 32'h0000_0000);
        go();
        repeat (4) @(posedge clk);
        rd(c_code_result, rdata); check_val("zero_word_result", rdata, 32'h2144_DF1C);
        rd(c_code_status, rdata); check_val("zero_word_status", rdata, 32'h1);
        check_val("zero_word_no_irq", {31'b0, bus.int_req}, 32'h0);

        // "abcd" with interrupt, latency, then CLEAR.
        wr(c_code_config, 32'h8000_0001);
        wr(c_code_mem_in, 32'h6463_6261);
        go();
        wait_int(20, lat); check_val("abcd_latency", lat, 32'd3);
        rd(c_code_result, rdata); check_val("abcd_result", rdata, 32'hED82_CD11);
        rd(c_code_status, rdata); check_val("abcd_status", rdata, 32'h5);
        wr(c_code_clear, 32'h0);
        check_val("abcd_clear_irq", {31'b0, bus.int_req}, 32'h0);
        rd(c_code_status, rdata); check_val("abcd_clear_status", rdata, 32'h0);
        rd(c_code_result, rdata);
        rd(5'h1F, rdata); check_val("undef_read_hold", rdata, 32'hED82_CD11);

        // Zero length.
        wr(c_code_config, 32'h0000_0000);
        go();
        rd(c_code_status, rdata); check_val("len0_status_busy", rdata, 32'h2);
        rd(c_code_status, rdata); check_val("len0_status_done", rdata, 32'h1);
        rd(c_code_result, rdata); check_val("len0_result", rdata, 32'h0);
        check_val("len0_no_irq", {31'b0, bus.int_req}, 32'h0);
        wr(c_code_config, 32'h8000_0000);
        go();
        wait_int(10, lat); check_val("len0_latency", lat, 32'd1);
        wr(c_code_clear, 32'h0);

        // Pointer wrap and length saturation.
        for (int i = 0; i <= MEM_DEPTH; i++) begin
            w = {8'(i), 8'hA5, 8'(i * 3), 8'h5A};
            gold[i % MEM_DEPTH] = w;
            wr(c_code_mem_in, w);
        end
        wr(c_code_config, 32'h8000_01FF);
        go();
        wait_int(60, lat); check_val("sat_latency", lat, MEM_DEPTH + 2);
        rd(c_code_result, rdata); check_val("sat_wrap_result", rdata, crc_model(MEM_DEPTH));
        wr(c_code_clear, 32'h0);

        // Start, MEM_IN and CONFIG while busy are all ignored.
        gold[0] = 32'h1111_1111; gold[1] = 32'h2222_2222; gold[2] = 32'h3333_3333;
        wr(c_code_config, 32'h8000_0003);
        for (int i = 0; i < 3; i++) wr(c_code_mem_in, gold[i]);
        go();
        rd(c_code_status, rdata); check_val("busy_status", rdata, 32'h2);
        go();
        wr(c_code_mem_in, 32'hDEAD_BEEF);
        wr(c_code_config, 32'h8000_0002);
        wait_int(20, lat); check_val("busy_irq_seen", {31'b0, bus.int_req}, 32'h1);
        rd(c_code_result, rdata); check_val("busy_result", rdata, crc_model(3));
        wr(c_code_clear, 32'h0);
        gold[3] = 32'h4444_4444;
        wr(c_code_mem_in, gold[3]);
        wr(c_code_config, 32'h8000_0004);
        go();
        wait_int(20, lat); check_val("busy_followup_latency", lat, 32'd6);
        rd(c_code_result, rdata); check_val("busy_followup_result", rdata, crc_model(4));
        wr(c_code_clear, 32'h0);

        // Start with a simultaneous MEM_IN uses the pre-write contents.
        wr(c_code_config, 32'h8000_0001);
        wr(c_code_mem_in, 32'h6463_6261);
        gold[0] = 32'h6463_6261;
        wr(c_code_config, 32'h8000_0001);
        go_wr(c_code_mem_in, 32'h0000_0000);
        wait_int(20, lat);
        rd(c_code_result, rdata); check_val("start_with_write_result", rdata, 32'hED82_CD11);
        wr(c_code_clear, 32'h0);

        // CLEAR on the completing edge loses.
        wr(c_code_config, 32'h8000_0001);
        go();
        repeat (2) @(posedge clk);
        wr(c_code_clear, 32'h0);
        check_val("clear_race_irq", {31'b0, bus.int_req}, 32'h1);
        rd(c_code_status, rdata); check_val("clear_race_status", rdata, 32'h5);

        // Read and write in one cycle.
        rdwr(c_code_clear, 32'h0, rdata);
        check_val("rdwr_hold", rdata, 32'h5);
        check_val("rdwr_clear_irq", {31'b0, bus.int_req}, 32'h0);

        // Reset mid-run, then a fresh run over the retained memory.
        wr(c_code_config, 32'h8000_0004);
        go();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        repeat (8) @(posedge clk); #1;
        check_val("abort_no_irq", {31'b0, bus.int_req}, 32'h0);
        rd(c_code_status, rdata); check_val("abort_status", rdata, 32'h0);
        rd(c_code_result, rdata); check_val("abort_result", rdata, 32'h0);
        wr(c_code_config, 32'h8000_0004);
        go();
        wait_int(20, lat); check_val("rerun_latency", lat, 32'd6);
        rd(c_code_result, rdata); check_val("rerun_result", rdata, crc_model(4));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
